// File: rtl/wb_core_arbiter_pkg.sv
// Shared types and constants for the instruction/data Wishbone arbiter.
package wb_core_arbiter_pkg;

    localparam int RegBus    = 32;
    localparam int WbAddrBus = RegBus;
    localparam int WbDataBus = RegBus;
    localparam int WbSelBus  = RegBus / 8;
    localparam int WdogW     = 16;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_D    = 2'b01;
    localparam logic [1:0] OWN_I    = 2'b10;

    // State codes equal the owner encoding so owner_o is the state itself.
    typedef enum logic [1:0] {
        ST_IDLE  = OWN_NONE,
        ST_OWN_D = OWN_D,
        ST_OWN_I = OWN_I
    } arb_state_e;

    typedef struct packed {
        logic [WbAddrBus-1:0] addr;
        logic [WbDataBus-1:0] data;
        logic                 we;
        logic [WbSelBus-1:0]  sel;
        logic                 stb;
        logic                 cyc;
    } wb_req_t;

    function automatic logic wb_req_valid(wb_req_t r);
        return r.cyc && r.stb;
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Cycle counter that pulses expire on the LIMIT-th consecutive enabled cycle.
module wb_watchdog
    import wb_core_arbiter_pkg::*;
#(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expire
);

    localparam logic [WdogW-1:0] LAST = WdogW'(LIMIT - 1);

    logic [WdogW-1:0] cnt;

    assign expire = en && (cnt == LAST);

    // Clearing on expire as well keeps the counter from ever wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/wb_core_arbiter.sv
// Two-master (data, instruction) to one-slave Wishbone arbiter with fair
// alternation, whole-cycle grants and a transfer watchdog.
module wb_core_arbiter
    import wb_core_arbiter_pkg::*;
#(
    parameter int unsigned          TIMEOUT_CYCLES = 255,
    parameter logic [WbDataBus-1:0] TIMEOUT_DATA   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WbAddrBus-1:0] d_addr_i,
    input  logic [WbDataBus-1:0] d_data_i,
    input  logic                 d_we_i,
    input  logic [WbSelBus-1:0]  d_sel_i,
    input  logic                 d_stb_i,
    input  logic                 d_cyc_i,
    output logic [WbDataBus-1:0] d_data_o,
    output logic                 d_ack_o,
    input  logic [WbAddrBus-1:0] i_addr_i,
    input  logic [WbDataBus-1:0] i_data_i,
    input  logic                 i_we_i,
    input  logic [WbSelBus-1:0]  i_sel_i,
    input  logic                 i_stb_i,
    input  logic                 i_cyc_i,
    output logic [WbDataBus-1:0] i_data_o,
    output logic                 i_ack_o,
    output logic [WbAddrBus-1:0] s_addr_o,
    output logic [WbDataBus-1:0] s_data_o,
    output logic                 s_we_o,
    output logic [WbSelBus-1:0]  s_sel_o,
    output logic                 s_stb_o,
    output logic                 s_cyc_o,
    input  logic [WbDataBus-1:0] s_data_i,
    input  logic                 s_ack_i,
    output logic                 timeout_o,
    output logic [1:0]           owner_o
);

    arb_state_e state, state_nx;
    logic       last_i, last_i_nx;

    wb_req_t d_req, i_req, cur;
    logic    d_rq, i_rq;
    logic    own_d, own_i, owning;
    logic    ack, abort, expire;
    logic    wd_en, wd_clr;
    logic    bus_en;

    assign d_req = '{addr: d_addr_i, data: d_data_i, we: d_we_i,
                     sel: d_sel_i, stb: d_stb_i, cyc: d_cyc_i};
    assign i_req = '{addr: i_addr_i, data: i_data_i, we: i_we_i,
                     sel: i_sel_i, stb: i_stb_i, cyc: i_cyc_i};

    assign d_rq    = wb_req_valid(d_req);
    assign i_rq    = wb_req_valid(i_req);
    assign owner_o = state;

    always_comb begin
        own_d  = (state == ST_OWN_D);
        own_i  = (state == ST_OWN_I);
        owning = own_d || own_i;
        cur    = own_i ? i_req : d_req;
        // An ack wins over a simultaneous cyc drop; the dropped master ignores it.
        ack    = owning && s_ack_i;
        abort  = owning && !s_ack_i && !cur.cyc;
        wd_en  = owning && !s_ack_i && cur.cyc;
        wd_clr = !owning || ack || abort;
    end

    wb_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .en     (wd_en),
        .clr    (wd_clr),
        .expire (expire)
    );

    always_comb begin
        state_nx  = state;
        last_i_nx = last_i;
        case (state)
            ST_IDLE: begin
                if (d_rq && i_rq) begin
                    state_nx = last_i ? ST_OWN_D : ST_OWN_I;
                end else if (d_rq) begin
                    state_nx = ST_OWN_D;
                end else if (i_rq) begin
                    state_nx = ST_OWN_I;
                end
            end
            ST_OWN_D, ST_OWN_I: begin
                if (ack || abort || expire) begin
                    state_nx  = ST_IDLE;
                    last_i_nx = own_i;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            last_i    <= 1'b1;
            timeout_o <= 1'b0;
        end else begin
            state  <= state_nx;
            last_i <= last_i_nx;
            if (expire) begin
                timeout_o <= 1'b1;
            end
        end
    end

    // rst gates the outputs directly so nothing leaks onto either bus while
    // reset is held, even before the first reset edge.
    always_comb begin
        bus_en   = rst && owning;
        s_addr_o = '0;
        s_data_o = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        if (bus_en) begin
            s_addr_o = cur.addr;
            s_data_o = cur.data;
            s_we_o   = cur.we;
            s_sel_o  = cur.sel;
            s_stb_o  = cur.stb && !expire;
            s_cyc_o  = cur.cyc && !expire;
        end
    end

    always_comb begin
        d_ack_o  = 1'b0;
        d_data_o = '0;
        i_ack_o  = 1'b0;
        i_data_o = '0;
        if (rst && own_d) begin
            d_ack_o  = s_ack_i || expire;
            d_data_o = expire ? TIMEOUT_DATA : s_data_i;
        end
        if (rst && own_i) begin
            i_ack_o  = s_ack_i || expire;
            i_data_o = expire ? TIMEOUT_DATA : s_data_i;
        end
    end

endmodule

// File: tb/tb_wb_core_arbiter.sv
// Directed bench for wb_core_arbiter; acks are scored against a queue of expected results.
module tb_wb_core_arbiter;
    import wb_core_arbiter_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] d_addr_i = '0, d_data_i = '0, i_addr_i = '0, i_data_i = '0;
    logic        d_we_i = 1'b0, d_stb_i = 1'b0, d_cyc_i = 1'b0;
    logic        i_we_i = 1'b0, i_stb_i = 1'b0, i_cyc_i = 1'b0;
    logic [3:0]  d_sel_i = '0, i_sel_i = '0;
    logic [31:0] s_data_i = '0;
    logic        s_ack_i = 1'b0;
    logic [31:0] d_data_o, i_data_o, s_addr_o, s_data_o;
    logic        d_ack_o, i_ack_o, s_we_o, s_stb_o, s_cyc_o, timeout_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  owner_o;

    typedef struct {
        logic [1:0]  who;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    wb_core_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_DATA(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
        .d_stb_i(d_stb_i), .d_cyc_i(d_cyc_i), .d_data_o(d_data_o), .d_ack_o(d_ack_o),
        .i_addr_i(i_addr_i), .i_data_i(i_data_i), .i_we_i(i_we_i), .i_sel_i(i_sel_i),
        .i_stb_i(i_stb_i), .i_cyc_i(i_cyc_i), .i_data_o(i_data_o), .i_ack_o(i_ack_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
        .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_data_i(s_data_i), .s_ack_i(s_ack_i),
        .timeout_o(timeout_o), .owner_o(owner_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic on, input logic [31:0] a);
        d_cyc_i = on; d_stb_i = on; d_addr_i = a; d_data_i = ~a; d_we_i = 1'b0; d_sel_i = 4'hF;
    endtask

    task automatic set_i(input logic on, input logic [31:0] a);
        i_cyc_i = on; i_stb_i = on; i_addr_i = a; i_data_i = ~a; i_we_i = 1'b0; i_sel_i = 4'hF;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    // Every master ack must match the oldest expected result.
    always @(negedge clk) begin
        if (d_ack_o || i_ack_o) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'b0, i_ack_o, d_ack_o}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_owner", {30'b0, i_ack_o, d_ack_o}, {30'b0, e.who});
                chk("ack_data", (e.who == OWN_D) ? d_data_o : i_data_o, e.data);
                chk("other_data", (e.who == OWN_D) ? i_data_o : d_data_o, 32'h0);
            end
        end
    end

    initial begin
        // Reset, with a request and a stray ack present
        set_d(1'b1, 32'h3000_0000);
        s_ack_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
        step();
        step();
        @(negedge clk);
        chk("rst_owner", {30'b0, owner_o}, 32'h0);
        chk("rst_scyc", {31'b0, s_cyc_o}, 32'h0);
        chk("rst_dack", {31'b0, d_ack_o}, 32'h0);
        chk("rst_ddata", d_data_o, 32'h0);
        chk("rst_timeout", {31'b0, timeout_o}, 32'h0);
        step();
        rst = 1'b1; set_d(1'b0, 32'h0); s_ack_i = 1'b0; s_data_i = '0;

        // Single data read, slave acks on the third owned cycle
        set_d(1'b1, 32'h3000_0000);
        sb.push_back('{OWN_D, 32'hCAFE_BABE});
        @(negedge clk);
        chk("t1_idle", {30'b0, owner_o}, 32'h0);
        step();
        @(negedge clk);
        chk("t1_owner", {30'b0, owner_o}, {30'b0, OWN_D});
        chk("t1_saddr", s_addr_o, 32'h3000_0000);
        chk("t1_sdata", s_data_o, ~32'h3000_0000);
        chk("t1_scyc", {31'b0, s_cyc_o}, 32'h1);
        step();
        @(negedge clk);
        chk("t1_noack", {31'b0, d_ack_o}, 32'h0);
        step();
        s_ack_i = 1'b1; s_data_i = 32'hCAFE_BABE;
        @(negedge clk);
        chk("t1_dack", {31'b0, d_ack_o}, 32'h1);
        chk("t1_iack", {31'b0, i_ack_o}, 32'h0);
        step();
        s_ack_i = 1'b0; set_d(1'b0, 32'h0);
        @(negedge clk);
        chk("t1_done_owner", {30'b0, owner_o}, 32'h0);
        chk("t1_done_scyc", {31'b0, s_cyc_o}, 32'h0);

        // Tie after reset: data first, then strict alternation
        do_reset();
        set_d(1'b1, 32'h1000_0000);
        set_i(1'b1, 32'h2000_0000);
        for (int r = 0; r < 4; r++) begin
            logic [1:0] w;
            w = r[0] ? OWN_I : OWN_D;
            @(negedge clk);
            chk("tie_idle", {30'b0, owner_o}, 32'h0);
            step();
            @(negedge clk);
            chk("tie_owner", {30'b0, owner_o}, {30'b0, w});
            chk("tie_saddr", s_addr_o, (w == OWN_D) ? 32'h1000_0000 : 32'h2000_0000);
            step();
            s_ack_i = 1'b1; s_data_i = 32'hA000_0000 + r;
            sb.push_back('{w, 32'hA000_0000 + r});
            step();
            s_ack_i = 1'b0;
        end
        set_d(1'b0, 32'h0); set_i(1'b0, 32'h0);

        // Instruction flush abort with a data request pending
        set_i(1'b1, 32'h2000_0040);
        step();
        @(negedge clk);
        chk("fl_igrant", {30'b0, owner_o}, {30'b0, OWN_I});
        step();
        set_i(1'b0, 32'h0);
        set_d(1'b1, 32'h3000_0010);
        @(negedge clk);
        chk("fl_scyc", {31'b0, s_cyc_o}, 32'h0);
        chk("fl_iack", {31'b0, i_ack_o}, 32'h0);
        step();
        @(negedge clk);
        chk("fl_idle", {30'b0, owner_o}, 32'h0);
        step();
        s_ack_i = 1'b1; s_data_i = 32'h0BAD_F00D;
        sb.push_back('{OWN_D, 32'h0BAD_F00D});
        @(negedge clk);
        chk("fl_dgrant", {30'b0, owner_o}, {30'b0, OWN_D});
        step();
        s_ack_i = 1'b0; set_d(1'b0, 32'h0);

        // Watchdog: slave never acks
        set_d(1'b1, 32'h3000_0020);
        sb.push_back('{OWN_D, 32'h0000_0000});
        for (int k = 1; k < int'(TO); k++) begin
            step();
            @(negedge clk);
            chk("to_noack", {31'b0, d_ack_o}, 32'h0);
            chk("to_scyc_on", {31'b0, s_cyc_o}, 32'h1);
        end
        step();
        @(negedge clk);
        chk("to_dack", {31'b0, d_ack_o}, 32'h1);
        chk("to_scyc_off", {31'b0, s_cyc_o}, 32'h0);
        chk("to_sstb_off", {31'b0, s_stb_o}, 32'h0);
        step();
        set_d(1'b0, 32'h0);
        @(negedge clk);
        chk("to_flag", {31'b0, timeout_o}, 32'h1);
        chk("to_idle", {30'b0, owner_o}, 32'h0);
        set_i(1'b1, 32'h2000_0080);
        step();
        s_ack_i = 1'b1; s_data_i = 32'h5555_AAAA;
        sb.push_back('{OWN_I, 32'h5555_AAAA});
        @(negedge clk);
        chk("to_next_owner", {30'b0, owner_o}, {30'b0, OWN_I});
        step();
        s_ack_i = 1'b0; set_i(1'b0, 32'h0);
        @(negedge clk);
        chk("to_flag_held", {31'b0, timeout_o}, 32'h1);

        // Ack lands exactly on the timeout cycle
        do_reset();
        set_d(1'b1, 32'h3000_0030);
        sb.push_back('{OWN_D, 32'h1234_5678});
        for (int k = 1; k < int'(TO); k++) step();
        step();
        s_ack_i = 1'b1; s_data_i = 32'h1234_5678;
        @(negedge clk);
        chk("race_scyc", {31'b0, s_cyc_o}, 32'h1);
        step();
        s_ack_i = 1'b0; set_d(1'b0, 32'h0);
        @(negedge clk);
        chk("race_flag", {31'b0, timeout_o}, 32'h0);
        step();
        @(negedge clk);
        chk("race_flag_later", {31'b0, timeout_o}, 32'h0);

        // Reset pulse during an instruction transfer, then a late slave ack
        set_i(1'b1, 32'h2000_00C0);
        step();
        @(negedge clk);
        chk("rm_owner", {30'b0, owner_o}, {30'b0, OWN_I});
        chk("rm_scyc", {31'b0, s_cyc_o}, 32'h1);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        s_ack_i = 1'b1; s_data_i = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rm_post_owner", {30'b0, owner_o}, 32'h0);
        chk("rm_post_scyc", {31'b0, s_cyc_o}, 32'h0);
        chk("rm_post_sstb", {31'b0, s_stb_o}, 32'h0);
        chk("rm_post_saddr", s_addr_o, 32'h0);
        chk("rm_post_iack", {31'b0, i_ack_o}, 32'h0);
        chk("rm_post_idata", i_data_o, 32'h0);
        step();
        s_ack_i = 1'b0; set_i(1'b0, 32'h0);
        @(negedge clk);
        chk("rm_regrant", {30'b0, owner_o}, {30'b0, OWN_I});
        step();
        @(negedge clk);
        chk("rm_abort_idle", {30'b0, owner_o}, 32'h0);

        chk("sb_drained", sb.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_core_arbiter.md
Name: wb_core_arbiter

Overview:
- Two-master-to-one-slave Wishbone arbiter placed directly downstream of the core's instruction and data Wishbone master ports.
- Merges both ports onto the single shared system bus that carries ROM, RAM, UART and GPIO.
- Holds a grant for the whole bus cycle, alternates fairly between masters, and routes ack and read data back only to the owning master.
- Bounded-wait watchdog: a transfer that gets no ack is terminated so the core cannot hang.

Parameters:
- TIMEOUT_CYCLES, 255: cycles to wait for slave ack before forcing termination; valid range 1..65535.
- TIMEOUT_DATA, 32'h0000_0000: read data returned to the master on a forced termination.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- d_addr_i / d_data_i  in  32 / 32  data-master address, write data
- d_we_i / d_sel_i / d_stb_i / d_cyc_i  in  1 / 4 / 1 / 1  data-master controls
- d_data_o / d_ack_o  out  32 / 1  data-master read data, ack
- i_addr_i / i_data_i  in  32 / 32  instruction-master address, write data
- i_we_i / i_sel_i / i_stb_i / i_cyc_i  in  1 / 4 / 1 / 1  instruction-master controls
- i_data_o / i_ack_o  out  32 / 1  instruction-master read data, ack
- s_addr_o / s_data_o  out  32 / 32  shared-bus address, write data
- s_we_o / s_sel_o / s_stb_o / s_cyc_o  out  1 / 4 / 1 / 1  shared-bus controls
- s_data_i / s_ack_i  in  32 / 1  shared-bus read data, ack
- timeout_o  out  1  sticky flag: at least one forced termination since reset
- owner_o  out  2  current owner: 00 none, 01 data, 10 instruction

Behaviour:
- Reset and clocking:
  - One clock, clk. Reset rst is synchronous and active-low: rst==0 sampled at a rising clk edge resets the block.
  - Reset values: state IDLE, owner_o=00, last_grant=instruction (so data wins the first tie), wdog=0, timeout_o=0.
  - While in reset, all s_* outputs are 0, and d_ack_o, i_ack_o, d_data_o, i_data_o are 0.
- States: IDLE, OWN_D, OWN_I, with owner_o encoding the state.
- IDLE:
  - Request means cyc_i && stb_i.
  - One requester: go to its OWN state next cycle.
  - Both request: grant the master that is not last_grant.
  - No request: stay in IDLE.
  - Arbitration latency is one cycle, because the grant is registered.
- OWN_x bus driving:
  - s_addr_o, s_data_o, s_we_o, s_sel_o, s_stb_o and s_cyc_o are combinational copies of master x's signals.
  - The other master sees ack=0 and data=0.
- OWN_x ack path:
  - x_ack_o = s_ack_i, and x_data_o = s_data_i, both combinational with zero added latency.
  - On s_ack_i: return to IDLE, set last_grant=x, and clear wdog.
  - A new request can therefore be granted no sooner than the cycle after an ack. A back-to-back request from the same master waits exactly one IDLE cycle.
- Abort: if x_cyc_i drops while in OWN_x (core flush), go to IDLE next cycle with no ack, set last_grant=x, clear wdog.
- Watchdog:
  - In OWN_x, wdog increments each cycle without ack.
  - On the cycle where wdog==TIMEOUT_CYCLES-1 with no s_ack_i, the block itself asserts x_ack_o=1 and x_data_o=TIMEOUT_DATA for one cycle.
  - In that same cycle s_stb_o and s_cyc_o are forced to 0.
  - Next state IDLE; timeout_o set to 1 and held until reset.
- Simultaneous events:
  - s_ack_i on the timeout cycle counts as a normal ack: no timeout is flagged and slave data is returned.
  - s_ack_i in IDLE is ignored.
  - A cyc drop on the same cycle as s_ack_i is treated as an ack; the master ignores it.
- Width rules: wdog is 16 bits, compared against TIMEOUT_CYCLES-1, and never wraps because it clears on leaving OWN.
- Reset mid-transfer: ownership is dropped and all bus outputs are 0 in the following cycle. Any late slave ack is ignored.

Decomposition:
- Shared package constants:
  - owner encodings OWN_NONE=2'b00, OWN_D=2'b01, OWN_I=2'b10
  - ST_IDLE, ST_OWN_D, ST_OWN_I
  - WbAddrBus/WbDataBus widths, reusing RegBus (32)
- One sub-module: wb_watchdog (enable, clear, parameterised limit, expire pulse). Everything else lives in the arbiter.

Test Plan:
- Single data read: d_cyc/stb=1, addr 0x3000_0000; slave acks 2 cycles after grant with 0xCAFEBABE -> owner_o=01 one cycle after request; d_ack_o=1 with d_data_o=0xCAFEBABE; i_ack_o stays 0.
- Tie: both masters request in the same cycle right after reset -> data is granted first; after its ack, the instruction master is granted after one IDLE cycle; a repeated tie then goes to data again (strict alternation over 4 rounds).
- Flush abort: instruction master granted, i_cyc_i drops before any ack -> IDLE next cycle, no i_ack_o, s_cyc_o=0; a pending data request is granted the cycle after.
- Timeout: TIMEOUT_CYCLES=4, slave never acks -> the 4th owned cycle gives d_ack_o=1 and d_data_o=0, s_cyc_o=0 in that cycle, timeout_o=1 and held; a subsequent normal transfer succeeds with timeout_o still 1.
- Race: slave ack arrives exactly on the timeout cycle with 0x1234_5678 -> master gets 0x1234_5678 and timeout_o stays 0.
- Reset mid-transfer: rst=0 for one edge during OWN_I -> all s_* outputs 0 and owner_o=00 next cycle; a late s_ack_i produces no master ack.
